// File: rtl/frame_buf_writer_pkg.sv
// Shared frame-buffer constants and writer FSM encoding, also imported by the VGA reader.
package frame_buf_writer_pkg;

  localparam int unsigned FB_SHOW_WIDTH  = 320;
  localparam int unsigned FB_SHOW_HEIGHT = 200;
  localparam int unsigned FB_FRAME_N     = FB_SHOW_WIDTH * FB_SHOW_HEIGHT;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_WAIT_SWAP = 2'd2
  } fb_state_e;

endpackage

// File: rtl/frame_buf_writer.sv
// Writes one binary frame into the back bank of a double-buffered frame store and
// hands the bank to the VGA reader once a complete, correctly sized frame is in.
module frame_buf_writer
  import frame_buf_writer_pkg::*;
#(
  parameter int unsigned SHOW_WIDTH  = FB_SHOW_WIDTH,
  parameter int unsigned SHOW_HEIGHT = FB_SHOW_HEIGHT,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              din_vld,
  input  logic              din_sop,
  input  logic              din_eop,
  input  logic              rd_end,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic              wr_data,
  output logic              wr_end,
  output logic              wr_addr_sel,
  output logic              frame_err,
  output logic              frame_drop
);

  localparam int unsigned       FRAME_N  = SHOW_WIDTH * SHOW_HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_N - 1);

  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wr_en_q, wr_en_d;
  logic              wr_data_q, wr_data_d;
  logic              wr_end_q, wr_end_d;
  logic              sel_q, sel_d;
  logic              err_q, err_d;
  logic              drop_q, drop_d;

  // accept/idx: a pixel that takes part in normal frame assembly at index idx
  logic              accept;
  logic [ADDR_W-1:0] idx;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_addr_d = wr_addr_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    wr_end_d  = wr_end_q;
    sel_d     = sel_q;
    err_d     = 1'b0;
    drop_d    = 1'b0;
    accept    = 1'b0;
    idx       = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (din_vld && din_sop) begin
          accept = 1'b1;
          idx    = '0;
        end
      end
      ST_WRITE: begin
        if (din_vld) begin
          if (din_sop) begin
            // restart wins over eop: abandon the partial frame, begin again at 0
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = din;
            cnt_d     = ADDR_W'(1);
            err_d     = 1'b1;
          end else begin
            accept = 1'b1;
          end
        end
      end
      ST_WAIT_SWAP: begin
        if (din_vld && din_sop) drop_d = 1'b1;
        if (rd_end) begin
          sel_d    = ~sel_q;
          wr_end_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      // the last index is only written when it really closes the frame
      if (din_eop || idx != LAST_IDX) begin
        wr_en_d   = 1'b1;
        wr_addr_d = idx;
        wr_data_d = din;
      end
      if (din_eop && idx == LAST_IDX) begin
        wr_end_d = 1'b1;
        state_d  = ST_WAIT_SWAP;
        cnt_d    = '0;
      end else if (din_eop || idx == LAST_IDX) begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = ST_WRITE;
        cnt_d   = idx + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= 1'b0;
      wr_end_q  <= 1'b0;
      sel_q     <= 1'b1;
      err_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_addr_q <= wr_addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_end_q  <= wr_end_d;
      sel_q     <= sel_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
    end
  end

  assign wr_addr     = wr_addr_q;
  assign wr_en       = wr_en_q;
  assign wr_data     = wr_data_q;
  assign wr_end      = wr_end_q;
  assign wr_addr_sel = sel_q;
  assign frame_err   = err_q;
  assign frame_drop  = drop_q;

endmodule

// File: tb/tb_frame_buf_writer.sv
// Randomized bench for frame_buf_writer on a reduced 16x8 frame, checked cycle by
// cycle against a frame-level model of the writer rules.
module tb_frame_buf_writer;

  localparam int W  = 16;
  localparam int H  = 8;
  localparam int AW = 8;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          din, din_vld, din_sop, din_eop, rd_end;
  logic [AW-1:0] wr_addr;
  logic          wr_en, wr_data, wr_end, wr_addr_sel, frame_err, frame_drop;

  frame_buf_writer #(
    .SHOW_WIDTH (W),
    .SHOW_HEIGHT(H),
    .ADDR_W     (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_vld    (din_vld),
    .din_sop    (din_sop),
    .din_eop    (din_eop),
    .rd_end     (rd_end),
    .wr_addr    (wr_addr),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_end     (wr_end),
    .wr_addr_sel(wr_addr_sel),
    .frame_err  (frame_err),
    .frame_drop (frame_drop)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // frame-level model: where we are in a frame and what the bus must show next
  bit   in_frame, waiting;
  int   pix;
  logic exp_en, exp_data, exp_end, exp_sel, exp_err, exp_drop;
  int   exp_addr;
  int   wr_seen, err_seen, drop_seen;

  task automatic model_reset();
    in_frame = 0; waiting = 0; pix = 0;
    exp_en = 0; exp_data = 0; exp_end = 0; exp_sel = 1;
    exp_err = 0; exp_drop = 0; exp_addr = 0;
  endtask

  task automatic model_write(input int a, input logic d);
    exp_en = 1; exp_addr = a; exp_data = d;
  endtask

  task automatic model_step(input logic v, s, e, d, r);
    int k;
    exp_en = 0; exp_err = 0; exp_drop = 0;
    if (waiting) begin
      if (v && s) exp_drop = 1;
      if (r) begin waiting = 0; exp_sel = ~exp_sel; exp_end = 0; end
    end else if (v && s && in_frame) begin
      model_write(0, d); exp_err = 1; pix = 1;
    end else if (v && (in_frame || s)) begin
      k = in_frame ? pix : 0;
      if (e) begin
        model_write(k, d);
        if (k == N - 1) begin exp_end = 1; waiting = 1; end
        else exp_err = 1;
        in_frame = 0;
      end else if (k == N - 1) begin
        exp_err = 1; in_frame = 0;
      end else begin
        model_write(k, d); pix = k + 1; in_frame = 1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("wr_en", wr_en, exp_en);
    if (exp_en) begin
      chk("wr_addr", wr_addr, exp_addr);
      chk("wr_data", wr_data, exp_data);
    end
    chk("wr_end", wr_end, exp_end);
    chk("wr_addr_sel", wr_addr_sel, exp_sel);
    chk("frame_err", frame_err, exp_err);
    chk("frame_drop", frame_drop, exp_drop);
  endtask

  task automatic cycle(input logic v, s, e, d, r);
    din_vld = v; din_sop = s; din_eop = e; din = d; rd_end = r;
    model_step(v, s, e, d, r);
    @(posedge clk);
    #1;
    if (wr_en) wr_seen++;
    if (frame_err) err_seen++;
    if (frame_drop) drop_seen++;
    check_outputs();
  endtask

  task automatic clear_counts();
    wr_seen = 0; err_seen = 0; drop_seen = 0;
  endtask

  task automatic send_frame(input int len, input bit with_eop, input int gap);
    for (int i = 0; i < len; i++) begin
      for (int g = 0; g < gap; g++) cycle(0, 0, 0, 1'($urandom), 0);
      cycle(1, i == 0, with_eop && (i == len - 1), 1'($urandom), 0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_addr"}, wr_addr, 0);
    chk({tag, "_en"}, wr_en, 0);
    chk({tag, "_data"}, wr_data, 0);
    chk({tag, "_end"}, wr_end, 0);
    chk({tag, "_sel"}, wr_addr_sel, 1);
    chk({tag, "_err"}, frame_err, 0);
    chk({tag, "_drop"}, frame_drop, 0);
  endtask

  initial begin
    rst_n = 0; din = 0; din_vld = 0; din_sop = 0; din_eop = 0; rd_end = 0;
    model_reset();
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    rst_n = 1;
    cycle(0, 0, 0, 0, 1);  // rd_end in IDLE must be ignored

    clear_counts();
    send_frame(N, 1, 0);
    chk("full_writes", wr_seen, N);
    chk("full_last_addr", wr_addr, N - 1);
    chk("full_err", err_seen, 0);
    $display("full frame: writes=%0d err=%0d wr_end=%0b", wr_seen, err_seen, wr_end);

    clear_counts();
    repeat (3) cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 0, 1, 0);            // sop while waiting for swap
    cycle(1, 1, 0, 1, 1);            // sop on the swap edge
    chk("wait_drops", drop_seen, 2);
    chk("wait_writes", wr_seen, 0);
    $display("swap: sel=%0b wr_end=%0b drops=%0d", wr_addr_sel, wr_end, drop_seen);

    clear_counts();
    send_frame(101, 1, 0);           // eop on pixel 100
    chk("short_err", err_seen, 1);
    $display("short frame: writes=%0d err=%0d", wr_seen, err_seen);

    clear_counts();
    send_frame(N, 1, 2);             // valid every third cycle, into bank 0
    chk("sparse_writes", wr_seen, N);
    chk("sparse_last_addr", wr_addr, N - 1);
    $display("sparse frame: writes=%0d last=%0d", wr_seen, wr_addr);
    cycle(0, 0, 0, 0, 1);

    clear_counts();
    send_frame(50, 0, 0);            // restart partway through
    send_frame(N, 1, 0);
    chk("restart_err", err_seen, 1);
    $display("restart: writes=%0d err=%0d", wr_seen, err_seen);
    cycle(0, 0, 0, 0, 1);

    clear_counts();
    send_frame(N, 0, 0);             // last index without eop is not written
    chk("noeop_writes", wr_seen, N - 1);
    cycle(1, 1, 1, 1, 0);            // sop+eop in IDLE is a length error
    chk("sopeop_err", err_seen, 2);
    $display("length errors: writes=%0d err=%0d", wr_seen, err_seen);

    send_frame(60, 0, 0);            // reset in mid-frame
    rst_n = 0;
    #1;
    check_reset_values("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    cycle(1, 0, 1, 1, 0);            // no sop: ignored after reset
    cycle(1, 1, 0, 1, 0);
    $display("mid-frame reset: restart addr=%0d", wr_addr);

    for (int i = 0; i < 4000; i++) begin
      logic v, s, e;
      v = ($urandom_range(3) != 0);
      s = ($urandom_range(79) == 0);
      e = (in_frame && pix == N - 1) ? ($urandom_range(3) != 0) : ($urandom_range(99) == 0);
      cycle(v, s, e, 1'($urandom), $urandom_range(19) == 0);
    end
    $display("random phase done: checks=%0d", n_chk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
